bit_stream_serializer: RTL and testbench

- Upstream feeder for the one-hot serial sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them as a continuous bit stream, one bit per clk, on x.
- The detector samples x every cycle, so x is always defined; it holds IDLE_BIT whenever no word is being shifted.
- A one-entry holding buffer allows back-to-back words with no idle gap.

---
 rtl/ser_pkg.sv | 21 ++
 rtl/ser_hold_buffer.sv | 52 +++++
 rtl/bit_stream_serializer.sv | 133 +++++++++++++
 tb/tb_bit_stream_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the bit-stream serializer: FSM encoding, bit-counter
// sizing and the default idle line level.
package ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Counter must reach WIDTH when the parity cycle is present.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ser_hold_buffer.sv
// One-entry valid/ready holding register feeding the serializer shifter.
module ser_hold_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_full,
    input  logic             pop
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             accept_s;

    // pop is derived from registered state only, so in_ready never depends on in_valid
    assign in_ready = ~rst & (~full_q | pop);
    assign out_data = data_q;
    assign out_full = full_q;

    // next-state: a new word wins over a simultaneous pop
    always_comb begin
        accept_s = in_valid & in_ready;
        full_d   = full_q;
        data_d   = data_q;
        if (accept_s) begin
            data_d = in_data;
            full_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= {WIDTH{1'b0}};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-word to serial-bit converter feeding the sequence detector.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after every word.
module bit_stream_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
`ifdef SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sh_data_q, sh_data_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] hold_data_s;
    logic             hold_full_s;
    logic             last_s;
    logic             load_s;
    logic             out_bit_s;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    ser_hold_buffer #(.WIDTH(WIDTH)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (hold_data_s),
        .out_full (hold_full_s),
        .pop      (load_s)
    );

    // shifter FSM next-state; x is computed from next-state so it is a true flop
    always_comb begin
        state_d   = state_q;
        sh_data_d = sh_data_q;
        bit_cnt_d = bit_cnt_q;
        x_d       = IDLE_BIT;
        out_bit_s = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif
        last_s = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT);
        load_s = hold_full_s && ((state_q == ST_IDLE) || last_s);

        if (load_s) begin
            state_d   = ST_SHIFT;
            sh_data_d = hold_data_s;
            bit_cnt_d = {CNT_W{1'b0}};
`ifdef SERIALIZER_PARITY_EN
            par_d     = even_parity(32'(hold_data_s));
`endif
        end else if (last_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (state_q == ST_SHIFT) begin
            bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (MSB_FIRST != 0) begin
                sh_data_d = {sh_data_q[WIDTH-2:0], 1'b0};
            end else begin
                sh_data_d = {1'b0, sh_data_q[WIDTH-1:1]};
            end
        end else begin
            state_d = state_q;
        end

        if (MSB_FIRST != 0) begin
            out_bit_s = sh_data_d[WIDTH-1];
        end else begin
            out_bit_s = sh_data_d[0];
        end

        if (state_d == ST_SHIFT) begin
`ifdef SERIALIZER_PARITY_EN
            if (bit_cnt_d == CNT_W'(WIDTH)) begin
                x_d = par_d;
            end else begin
                x_d = out_bit_s;
            end
`else
            x_d = out_bit_s;
`endif
        end else begin
            x_d = IDLE_BIT;
        end
    end

    // shifter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sh_data_q <= {WIDTH{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
            x_q       <= IDLE_BIT;
`ifdef SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sh_data_q <= sh_data_d;
            bit_cnt_q <= bit_cnt_d;
            x_q       <= x_d;
`ifdef SERIALIZER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign x          = x_q;
    assign x_valid    = (state_q == ST_SHIFT);
    assign word_start = (state_q == ST_SHIFT) && (bit_cnt_q == {CNT_W{1'b0}});
    assign busy       = (state_q == ST_SHIFT) || hold_full_s;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer (WIDTH=8, MSB first, idle level 0).
module tb_bit_stream_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int WB = 9;
`else
    localparam int WB = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       x;
    logic       x_valid;
    logic       word_start;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic col_en = 1'b0;
    logic v_q[$];
    logic xb_q[$];
    logic ws_q[$];
    logic exp_q[$];

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_valid    (x_valid),
        .word_start (word_start),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (col_en) begin
            v_q.push_back(x_valid);
            xb_q.push_back(x);
            ws_q.push_back(word_start);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [7:0] w, output int waits);
        waits    = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        check_val("accept_timeout", 32'(waits < 40), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_word(input logic [7:0] w);
        for (int k = 7; k >= 0; k--) exp_q.push_back(w[k]);
`ifdef SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic clear_capture();
        v_q.delete();
        xb_q.delete();
        ws_q.delete();
        exp_q.delete();
    endtask

    // Entered at the negedge right after the accepting edge; checks exact latency.
    task automatic check_word_direct(input string tag, input logic [7:0] w, input logic par_exp);
        logic eb;
        check_val({tag, "_pre_valid"}, 32'(x_valid), 32'd0);
        check_val({tag, "_pre_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < WB; k++) begin
            @(negedge clk);
            eb = (k < 8) ? w[7-k] : par_exp;
            check_val({tag, "_bit"}, 32'(x), 32'(eb));
            check_val({tag, "_valid"}, 32'(x_valid), 32'd1);
            check_val({tag, "_start"}, 32'(word_start), 32'(k == 0));
        end
        @(negedge clk);
        check_val({tag, "_post_valid"}, 32'(x_valid), 32'd0);
        check_val({tag, "_post_x"}, 32'(x), 32'd0);
        check_val({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        int i0 = -1;
        for (int i = 0; i < v_q.size(); i++) begin
            if (v_q[i] && i0 < 0) i0 = i;
        end
        check_val({tag, "_found"}, 32'(i0 >= 0), 32'd1);
        if (i0 >= 0) begin
            check_val({tag, "_len"}, 32'(v_q.size() > i0 + exp_q.size()), 32'd1);
            if (v_q.size() > i0 + exp_q.size()) begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    check_val({tag, "_valid"}, 32'(v_q[i0+k]), 32'd1);
                    check_val({tag, "_bit"}, 32'(xb_q[i0+k]), 32'(exp_q[k]));
                    check_val({tag, "_start"}, 32'(ws_q[i0+k]), 32'((k % WB) == 0));
                end
                check_val({tag, "_tail_idle"}, 32'(v_q[i0+exp_q.size()]), 32'd0);
            end
        end
    endtask

    initial begin
        int w0, w1, w2;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // reset state
        #2;
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_x", 32'(x), 32'd0);
        check_val("rst_x_valid", 32'(x_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // idle after release
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("idle_x", 32'(x), 32'd0);
            check_val("idle_x_valid", 32'(x_valid), 32'd0);
            check_val("idle_in_ready", 32'(in_ready), 32'd1);
            check_val("idle_busy", 32'(busy), 32'd0);
        end

        // single word with exact latency
        push_word(8'hB0, w0);
        in_valid = 1'b0;
        check_word_direct("single_b0", 8'hB0, 1'b1);

        // back-to-back words, no gap
        clear_capture();
        col_en = 1'b1;
        add_word(8'hB0);
        add_word(8'h0B);
        push_word(8'hB0, w0);
        push_word(8'h0B, w1);
        in_valid = 1'b0;
        check_val("b2b_second_wait", 32'(w1), 32'd0);
        repeat (3 * WB) @(negedge clk);
        col_en = 1'b0;
        check_stream("b2b");

        // three words, backpressure on the third
        clear_capture();
        col_en = 1'b1;
        add_word(8'hC3);
        add_word(8'h5A);
        add_word(8'h81);
        push_word(8'hC3, w0);
        push_word(8'h5A, w1);
        check_val("bp_ready_low", 32'(in_ready), 32'd0);
        check_val("bp_busy", 32'(busy), 32'd1);
        push_word(8'h81, w2);
        in_valid = 1'b0;
        check_val("bp_wait_cycles", 32'(w2), 32'(WB - 1));
        repeat (4 * WB) @(negedge clk);
        col_en = 1'b0;
        check_stream("three");

        // reset in the middle of a word
        push_word(8'hFF, w0);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_x_before", 32'(x), 32'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_x", 32'(x), 32'd0);
        check_val("mid_rst_x_valid", 32'(x_valid), 32'd0);
        check_val("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("mid_rst_hold_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_val("mid_rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check_val("mid_rel_x_valid", 32'(x_valid), 32'd0);
        push_word(8'hA5, w0);
        in_valid = 1'b0;
        check_word_direct("after_rst_a5", 8'hA5, 1'b0);

`ifdef SERIALIZER_PARITY_EN
        // parity bit values
        push_word(8'h07, w0);
        in_valid = 1'b0;
        check_word_direct("par_07", 8'h07, 1'b1);
        push_word(8'h03, w0);
        in_valid = 1'b0;
        check_word_direct("par_03", 8'h03, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
